// File: rtl/plru_victim_selector.sv
// Per-set tree pseudo-LRU victim selector with per-way valid tracking.
// A request is captured in IDLE and the chosen way is held stable in HOLD until the fill is acknowledged.
`default_nettype none

module plru_victim_selector #(
  parameter int WAY_BITS = 3,
  parameter int SET_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                touch_valid,
  input  logic [SET_BITS-1:0] touch_set,
  input  logic [WAY_BITS-1:0] touch_way,
  input  logic                victim_req,
  input  logic [SET_BITS-1:0] victim_set,
  output logic                victim_ready,
  output logic                victim_valid,
  output logic [WAY_BITS-1:0] victim_way,
  input  logic                victim_ack
);

  localparam int WAYS      = 2 ** WAY_BITS;
  localparam int SETS      = 2 ** SET_BITS;
  localparam int TREE_BITS = WAYS - 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAYS-1:0]      valid_d [SETS];
  logic [TREE_BITS-1:0] plru_q  [SETS];
  logic [TREE_BITS-1:0] plru_d  [SETS];
  logic [0:0]           state_q, state_d;
  logic [WAY_BITS-1:0]  victim_way_q, victim_way_d;
  logic [SET_BITS-1:0]  held_set_q, held_set_d;

  // Walk root-to-leaf along the way index (MSB first), pointing each node away from it.
  function automatic logic [TREE_BITS-1:0] plru_update(
    input logic [TREE_BITS-1:0] tree,
    input logic [WAY_BITS-1:0]  way
  );
    logic [TREE_BITS-1:0] upd;
    logic [WAY_BITS-1:0]  node;
    logic [WAY_BITS-1:0]  rem;
    logic                 dir;
    upd  = tree;
    node = '0;
    rem  = way;
    for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
      dir       = rem[WAY_BITS-1];
      upd[node] = ~dir;
      node      = {node[WAY_BITS-2:0], 1'b0} + WAY_BITS'(1) + {{(WAY_BITS-1){1'b0}}, dir};
      rem       = rem << 1;
    end
    return upd;
  endfunction

  function automatic logic [WAY_BITS-1:0] plru_select(
    input logic [WAYS-1:0]      valid,
    input logic [TREE_BITS-1:0] tree
  );
    logic [WAY_BITS-1:0] sel;
    logic [WAY_BITS-1:0] node;
    logic                dir;
    sel  = '0;
    node = '0;
    for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
      dir  = tree[node];
      sel  = {sel[WAY_BITS-2:0], dir};
      node = {node[WAY_BITS-2:0], 1'b0} + WAY_BITS'(1) + {{(WAY_BITS-1){1'b0}}, dir};
    end
    // Descending scan so the lowest-indexed invalid way overrides the tree choice.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid[i]) sel = WAY_BITS'(i);
    end
    return sel;
  endfunction

  always_comb begin
    valid_d      = valid_q;
    plru_d       = plru_q;
    state_d      = state_q;
    victim_way_d = victim_way_q;
    held_set_d   = held_set_q;

    if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        valid_d[s] = '0;
        plru_d[s]  = '0;
      end
      state_d      = S_IDLE;
      victim_way_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (victim_req) begin
            victim_way_d = plru_select(valid_q[victim_set], plru_q[victim_set]);
            held_set_d   = victim_set;
            state_d      = S_HOLD;
          end
        end
        S_HOLD: begin
          if (victim_ack) begin
            valid_d[held_set_q][victim_way_q] = 1'b1;
            plru_d[held_set_q] = plru_update(plru_d[held_set_q], victim_way_q);
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Applied after the ack update so a same-set touch owns the shared path bits.
      if (touch_valid) begin
        plru_d[touch_set] = plru_update(plru_d[touch_set], touch_way);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
      state_q      <= S_IDLE;
      victim_way_q <= '0;
      held_set_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      plru_q       <= plru_d;
      state_q      <= state_d;
      victim_way_q <= victim_way_d;
      held_set_q   <= held_set_d;
    end
  end

  assign victim_ready = (state_q == S_IDLE);
  assign victim_valid = (state_q == S_HOLD);
  assign victim_way   = victim_way_q;

endmodule

`default_nettype wire

// File: tb/tb_plru_victim_selector.sv
// Scoreboard bench for plru_victim_selector: expected ways come from a reference PLRU model or fixed constants.
`default_nettype none

module tb_plru_victim_selector;

  localparam int WAY_BITS = 3;
  localparam int SET_BITS = 4;
  localparam int WAYS     = 8;
  localparam int SETS     = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                flush;
  logic                touch_valid;
  logic [SET_BITS-1:0] touch_set;
  logic [WAY_BITS-1:0] touch_way;
  logic                victim_req;
  logic [SET_BITS-1:0] victim_set;
  logic                victim_ready;
  logic                victim_valid;
  logic [WAY_BITS-1:0] victim_way;
  logic                victim_ack;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  bit [WAYS-1:0] m_valid [SETS];
  bit [WAYS-2:0] m_tree  [SETS];

  always #5 clk = ~clk;

  plru_victim_selector #(.WAY_BITS(WAY_BITS), .SET_BITS(SET_BITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .touch_valid (touch_valid),
    .touch_set   (touch_set),
    .touch_way   (touch_way),
    .victim_req  (victim_req),
    .victim_set  (victim_set),
    .victim_ready(victim_ready),
    .victim_valid(victim_valid),
    .victim_way  (victim_way),
    .victim_ack  (victim_ack)
  );

  // Heap position of the level-lvl node reached by a path prefix.
  function automatic int node_at(int lvl, int prefix);
    return (1 << lvl) - 1 + prefix;
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++) begin
      m_valid[s] = '0;
      m_tree[s]  = '0;
    end
  endfunction

  function automatic void m_update(int s, int w);
    for (int l = 0; l < WAY_BITS; l++) begin
      m_tree[s][node_at(l, w >> (WAY_BITS - l))] = (((w >> (WAY_BITS - 1 - l)) & 1) == 0);
    end
  endfunction

  function automatic int m_select(int s);
    int p;
    for (int w = 0; w < WAYS; w++) begin
      if (!m_valid[s][w]) return w;
    end
    p = 0;
    for (int l = 0; l < WAY_BITS; l++) begin
      p = (p << 1) | int'(m_tree[s][node_at(l, p)]);
    end
    return p;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 0; touch_valid = 0; touch_set = '0; touch_way = '0;
    victim_req = 0; victim_set = '0; victim_ack = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    m_clear();
    exp_q.delete();
    step();
  endtask

  task automatic fill_quiet(input int s, input int n);
    int w;
    for (int k = 0; k < n; k++) begin
      w = m_select(s);
      victim_req = 1; victim_set = s[SET_BITS-1:0];
      step();
      victim_req = 0; victim_ack = 1;
      m_valid[s][w] = 1'b1;
      m_update(s, w);
      step();
      victim_ack = 0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (victim_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", victim_ready); end
    checks++;
    if (victim_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", victim_valid); end
    checks++;
    if (victim_way !== 3'd0) begin errors++; $display("FAIL reset_way: got %0d expected 0", victim_way); end
  endtask

  task automatic test_fill_order();
    int e;
    for (int i = 0; i < WAYS; i++) begin
      victim_req = 1; victim_set = 4'd0;
      exp_q.push_back(i);
      step();
      victim_req = 0;
      checks++;
      if (victim_valid !== 1'b1 || victim_ready !== 1'b0) begin
        errors++; $display("FAIL fill_hold%0d: got valid=%b ready=%b expected valid=1 ready=0", i, victim_valid, victim_ready);
      end
      e = exp_q.pop_front();
      checks++;
      if (victim_way !== 3'(e)) begin errors++; $display("FAIL fill_way%0d: got %0d expected %0d", i, victim_way, e); end
      victim_ack = 1;
      m_valid[0][e] = 1'b1; m_update(0, e);
      step();
      victim_ack = 0;
      checks++;
      if (victim_valid !== 1'b0 || victim_ready !== 1'b1) begin
        errors++; $display("FAIL fill_release%0d: got valid=%b ready=%b expected valid=0 ready=1", i, victim_valid, victim_ready);
      end
    end
  endtask

  task automatic test_plru_walk();
    int e;
    int consts[3] = '{0, 4, 2};
    for (int k = 0; k < 3; k++) begin
      victim_req = 1; victim_set = 4'd0;
      exp_q.push_back(consts[k]);
      step();
      victim_req = 0;
      e = exp_q.pop_front();
      checks++;
      if (victim_way !== 3'(e)) begin errors++; $display("FAIL walk_way%0d: got %0d expected %0d", k, victim_way, e); end
      checks++;
      if (m_select(0) != e) begin errors++; $display("FAIL walk_model%0d: got %0d expected %0d", k, m_select(0), e); end
      victim_ack = 1;
      m_update(0, e);
      step();
      victim_ack = 0;
      if (k == 0) begin
        touch_valid = 1; touch_set = 4'd0; touch_way = 3'd0;
        m_update(0, 0);
        step();
        touch_valid = 0;
      end
    end
  endtask

  task automatic test_set_independence();
    int e;
    apply_reset();
    fill_quiet(3, WAYS);
    for (int k = 0; k < 2; k++) begin
      victim_req = 1; victim_set = 4'd0;
      exp_q.push_back(k);
      step();
      victim_req = 0;
      e = exp_q.pop_front();
      checks++;
      if (victim_way !== 3'(e)) begin errors++; $display("FAIL indep_way%0d: got %0d expected %0d", k, victim_way, e); end
      victim_ack = 1;
      m_valid[0][e] = 1'b1; m_update(0, e);
      step();
      victim_ack = 0;
    end
  endtask

  task automatic test_hold_stable();
    int e;
    int consts[2] = '{4, 1};
    apply_reset();
    fill_quiet(0, WAYS);
    victim_req = 1; victim_set = 4'd0;
    exp_q.push_back(0);
    step();
    e = exp_q.pop_front();
    // Keep req asserted on another set and touch the held set: neither may disturb the hold.
    victim_set = 4'd5;
    touch_valid = 1; touch_set = 4'd0; touch_way = 3'd0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (victim_valid !== 1'b1 || victim_way !== 3'(e)) begin
        errors++; $display("FAIL hold_stable%0d: got valid=%b way=%0d expected valid=1 way=%0d", c, victim_valid, victim_way, e);
      end
      m_update(0, 0);
      step();
    end
    victim_req = 0;
    victim_ack = 1; touch_way = 3'd2;
    m_update(0, e); m_update(0, 2);
    step();
    victim_ack = 0; touch_valid = 0;
    checks++;
    if (victim_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got %b expected 0", victim_valid); end
    for (int k = 0; k < 2; k++) begin
      victim_req = 1; victim_set = 4'd0;
      exp_q.push_back(consts[k]);
      step();
      victim_req = 0;
      e = exp_q.pop_front();
      checks++;
      if (victim_way !== 3'(e)) begin errors++; $display("FAIL ack_touch_way%0d: got %0d expected %0d", k, victim_way, e); end
      checks++;
      if (m_select(0) != e) begin errors++; $display("FAIL ack_touch_model%0d: got %0d expected %0d", k, m_select(0), e); end
      victim_ack = 1;
      m_update(0, e);
      step();
      victim_ack = 0;
    end
  endtask

  task automatic test_flush();
    int e;
    apply_reset();
    fill_quiet(0, 3);
    victim_req = 1; victim_set = 4'd0;
    exp_q.push_back(3);
    step();
    victim_req = 0;
    e = exp_q.pop_front();
    checks++;
    if (victim_way !== 3'(e)) begin errors++; $display("FAIL flush_pre_way: got %0d expected %0d", victim_way, e); end
    flush = 1; victim_ack = 1; touch_valid = 1; touch_set = 4'd0; touch_way = 3'd5;
    step();
    flush = 0; victim_ack = 0; touch_valid = 0;
    m_clear();
    checks++;
    if (victim_valid !== 1'b0 || victim_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state: got valid=%b ready=%b expected valid=0 ready=1", victim_valid, victim_ready);
    end
    victim_req = 1; victim_set = 4'd0;
    exp_q.push_back(0);
    step();
    victim_req = 0;
    e = exp_q.pop_front();
    checks++;
    if (victim_way !== 3'(e)) begin errors++; $display("FAIL flush_post_way: got %0d expected %0d", victim_way, e); end
    victim_ack = 1; m_valid[0][e] = 1'b1; m_update(0, e);
    step();
    victim_ack = 0;
  endtask

  task automatic test_async_reset();
    int e;
    apply_reset();
    fill_quiet(0, 2);
    victim_req = 1; victim_set = 4'd0;
    exp_q.push_back(2);
    step();
    victim_req = 0;
    e = exp_q.pop_front();
    checks++;
    if (victim_valid !== 1'b1 || victim_way !== 3'(e)) begin
      errors++; $display("FAIL arst_pre: got valid=%b way=%0d expected valid=1 way=%0d", victim_valid, victim_way, e);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (victim_valid !== 1'b0 || victim_ready !== 1'b1 || victim_way !== 3'd0) begin
      errors++; $display("FAIL arst_immediate: got valid=%b ready=%b way=%0d expected valid=0 ready=1 way=0", victim_valid, victim_ready, victim_way);
    end
    step();
    rst_n = 1'b1;
    m_clear();
    step();
    victim_req = 1; victim_set = 4'd0;
    exp_q.push_back(0);
    step();
    victim_req = 0;
    e = exp_q.pop_front();
    checks++;
    if (victim_way !== 3'(e)) begin errors++; $display("FAIL arst_post_way: got %0d expected %0d", victim_way, e); end
    victim_ack = 1; m_valid[0][e] = 1'b1; m_update(0, e);
    step();
    victim_ack = 0;
  endtask

  task automatic test_back_to_back();
    int e;
    apply_reset();
    fill_quiet(0, WAYS);
    victim_ack = 1;
    step();
    victim_ack = 0;
    checks++;
    if (victim_valid !== 1'b0) begin errors++; $display("FAIL idle_ack: got valid=%b expected 0", victim_valid); end
    // Request accepted together with a touch: selection sees the pre-touch tree.
    victim_req = 1; victim_set = 4'd0;
    touch_valid = 1; touch_set = 4'd0; touch_way = 3'd0;
    exp_q.push_back(m_select(0));
    m_update(0, 0);
    step();
    victim_req = 0; touch_valid = 0;
    e = exp_q.pop_front();
    checks++;
    if (victim_way !== 3'(e) || e != 0) begin errors++; $display("FAIL req_touch_way: got %0d expected 0 (model %0d)", victim_way, e); end
    victim_ack = 1; m_update(0, e);
    step();
    victim_ack = 0;
    victim_req = 1; victim_set = 4'd0;
    exp_q.push_back(m_select(0));
    step();
    victim_req = 0;
    e = exp_q.pop_front();
    checks++;
    if (victim_valid !== 1'b1 || victim_way !== 3'(e)) begin
      errors++; $display("FAIL b2b_way: got valid=%b way=%0d expected valid=1 way=%0d", victim_valid, victim_way, e);
    end
    victim_ack = 1; m_update(0, e);
    step();
    victim_ack = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    step();
    test_reset();
    test_fill_order();
    test_plru_walk();
    test_set_independence();
    test_hold_stable();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
